// File: rtl/digit_serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of digits processed per operation.
    function automatic int unsigned calc_n(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    // Digit counter width: clog2(N), never below one bit.
    function automatic int unsigned calc_cnt_w(input int unsigned width, input int unsigned digit);
        int unsigned w;
        w = $clog2(width / digit);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/digit_serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple chain of one-bit full-adder cells.
module digit_adder #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             c_in,
    output logic [DIGIT-1:0] s_d,
    output logic             c_out,
    output logic             c_msb_in
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = c_in;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s_d[i]     = a_d[i] ^ b_d[i] ^ w_c[i];
        assign w_c[i + 1] = (a_d[i] & b_d[i]) | (w_c[i] & (a_d[i] ^ b_d[i]));
    end

    assign c_out    = w_c[DIGIT];
    assign c_msb_in = w_c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder: WIDTH-bit a + b + cin, DIGIT bits per clock, LSB digit first.
// Optional signed-overflow output enabled by DIGIT_SERIAL_ADDER_OVF_EN.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned N     = calc_n(WIDTH, DIGIT);
    localparam int unsigned CNT_W = calc_cnt_w(WIDTH, DIGIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t           r_state,     w_state_nxt;
    logic [WIDTH-1:0] r_a,         w_a_nxt;
    logic [WIDTH-1:0] r_b,         w_b_nxt;
    logic [WIDTH-1:0] r_sum,       w_sum_nxt;
    logic             r_carry,     w_carry_nxt;
    logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic             r_cout,      w_cout_nxt;
    logic             r_in_ready,  w_in_ready_nxt;
    logic             r_out_valid, w_out_valid_nxt;

    logic [DIGIT-1:0] w_s_d;
    logic             w_c_out;
    logic [WIDTH-1:0] w_sum_shift;

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic             r_ovf, w_ovf_nxt;
    logic             w_c_msb_in;
`endif

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a_d      (r_a[DIGIT-1:0]),
        .b_d      (r_b[DIGIT-1:0]),
        .c_in     (r_carry),
        .s_d      (w_s_d),
        .c_out    (w_c_out),
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        .c_msb_in (w_c_msb_in)
`else
        .c_msb_in ()
`endif
    );

    // New digit enters at the top; after N shifts the sum is fully assembled.
    if (DIGIT == WIDTH) begin : g_sum_full
        assign w_sum_shift = w_s_d;
    end else begin : g_sum_shift
        assign w_sum_shift = {w_s_d, r_sum[WIDTH-1:DIGIT]};
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_sum_nxt       = r_sum;
        w_carry_nxt     = r_carry;
        w_cnt_nxt       = r_cnt;
        w_cout_nxt      = r_cout;
        w_in_ready_nxt  = r_in_ready;
        w_out_valid_nxt = r_out_valid;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        w_ovf_nxt       = r_ovf;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_a_nxt        = a;
                    w_b_nxt        = b;
                    w_carry_nxt    = cin;
                    w_cnt_nxt      = '0;
                    w_in_ready_nxt = 1'b0;
                    w_state_nxt    = ST_RUN;
                end
            end
            ST_RUN: begin
                w_a_nxt     = r_a >> DIGIT;
                w_b_nxt     = r_b >> DIGIT;
                w_sum_nxt   = w_sum_shift;
                w_carry_nxt = w_c_out;
                w_cnt_nxt   = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_LAST) begin
                    w_cout_nxt      = w_c_out;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = ST_DONE;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
                    w_ovf_nxt       = w_c_msb_in ^ w_c_out;
`endif
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_in_ready_nxt  = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_out_valid_nxt = 1'b0;
                w_in_ready_nxt  = 1'b1;
                w_state_nxt     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_sum       <= w_sum_nxt;
            r_carry     <= w_carry_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cout      <= w_cout_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            r_ovf       <= w_ovf_nxt;
`endif
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule
